// File: rtl/mlp_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// mlp_share_arbiter_if
//   Bundles the requester, MLP-core and result-register signals of the
//   shared MLP arbiter.
//
//   Parameters
//     NREQ : number of requesters
//     IDW  : width of res_id (2**IDW >= NREQ)
//
//   Signal groups
//     requesters : req (level), grant (one-hot owner), ack (1-cycle pulse)
//     MLP core   : mlp_start (pulse), mlp_done (level), mlp_maxi, mlp_answer
//     result     : res_valid/res_ready handshake, res_id, res_class,
//                  res_answer, res_err
//
//   Modports
//     master : the arbiter side (drives grant/ack/mlp_start/res_*)
//     slave  : the environment side (requesters, core, result consumer)
// ---------------------------------------------------------------------------
interface mlp_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ack;

    logic            mlp_start;
    logic            mlp_done;
    logic [9:0]      mlp_maxi;
    logic [79:0]     mlp_answer;

    logic            res_valid;
    logic            res_ready;
    logic [IDW-1:0]  res_id;
    logic [3:0]      res_class;
    logic [79:0]     res_answer;
    logic            res_err;

    modport master (
        input  req,
        output grant,
        output ack,
        output mlp_start,
        input  mlp_done,
        input  mlp_maxi,
        input  mlp_answer,
        output res_valid,
        input  res_ready,
        output res_id,
        output res_class,
        output res_answer,
        output res_err
    );

    modport slave (
        output req,
        input  grant,
        input  ack,
        input  mlp_start,
        output mlp_done,
        output mlp_maxi,
        output mlp_answer,
        input  res_valid,
        output res_ready,
        input  res_id,
        input  res_class,
        input  res_answer,
        input  res_err
    );
endinterface

// File: rtl/mlp_share_arbiter.sv
// ---------------------------------------------------------------------------
// mlp_share_arbiter
//   Round-robin arbiter and job sequencer sharing one MLP inference core
//   among NREQ requesters. Grants one requester, pulses mlp_start, waits for
//   a qualified mlp_done, captures the class vector (encoded) and scores into
//   a result register and hands it out over a valid/ready handshake. The
//   grant vector also steers the image mux in front of the core.
//
//   Parameters
//     NREQ    : number of requesters (2..8)
//     IDW     : width of res_id, 2**IDW >= NREQ
//     TIMEOUT : watchdog limit in BUSY cycles (only with MLP_ARB_WATCHDOG_EN)
//
//   Ports
//     clk : rising-edge clock
//     rst : synchronous, active-high reset
//     bus : mlp_share_arbiter_if.master (requesters, core, result)
//
//   Build option
//     MLP_ARB_WATCHDOG_EN : when defined, a BUSY watchdog aborts a job that
//                           never finishes and flags it with res_err.
//                           When undefined BUSY waits forever, res_err = 0.
// ---------------------------------------------------------------------------
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; pick next eligible requester round-robin from ptr
// GRANT | grant held one cycle so the image mux settles
// START | mlp_start pulse; armed cleared
// BUSY  | waiting for a done that was preceded by done=0 (armed)
// HOLD  | result valid; waiting for res_ready, then ack and release
// ---------------------------------------------------------------------------
module mlp_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    mlp_share_arbiter_if.master bus
);

    if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TIMEOUT < 1 || TIMEOUT > 8191) begin : g_bad_param
        $error("mlp_share_arbiter: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_START = 3'd2,
        S_BUSY  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            armed_q, armed_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            res_valid_q, res_valid_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [3:0]      res_class_q, res_class_d;
    logic [79:0]     res_answer_q, res_answer_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] ack;
    logic [IDW-1:0]  pick;
    logic            found;
    logic            done_qual;
    logic            handshake;
    logic            wd_expire;
    logic            mlp_start;

    // Index of the single set bit, 4'hF for zero or multiple bits set.
    function automatic logic [3:0] encode_class(input logic [9:0] v);
        logic [3:0] idx;
        int         n;
        idx = 4'hF;
        n   = 0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
                n   = n + 1;
                idx = 4'(i);
            end
        end
        return (n == 1) ? idx : 4'hF;
    endfunction

    // The requester acked last cycle is masked so it cannot win again
    // immediately while its req is still falling.
    assign eligible = bus.req & ~ack_q;

    // First eligible requester at or above ptr, wrapping at NREQ.
    always_comb begin
        int j;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && eligible[j]) begin
                found = 1'b1;
                pick  = IDW'(j);
            end
        end
    end

    // A done seen before the core has dropped done once is a leftover from
    // an earlier job and must not be captured.
    assign done_qual = (state_q == S_BUSY) && armed_q && bus.mlp_done;
    assign handshake = (state_q == S_HOLD) && res_valid_q && bus.res_ready;

`ifdef MLP_ARB_WATCHDOG_EN
    localparam logic [12:0] WD_LOAD = 13'(TIMEOUT - 1);

    logic [12:0] wd_cnt_q, wd_cnt_d;
    logic        res_err_q, res_err_d;

    // Down-counter loaded in START so it hits zero on the TIMEOUT-th BUSY
    // cycle; a qualified done in that same cycle still wins.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == S_START) begin
            wd_cnt_d = WD_LOAD;
        end else if (state_q == S_BUSY && wd_cnt_q != 13'd0) begin
            wd_cnt_d = wd_cnt_q - 13'd1;
        end
    end

    assign wd_expire = (state_q == S_BUSY) && !done_qual && (wd_cnt_q == 13'd0);

    always_comb begin
        res_err_d = res_err_q;
        if (done_qual) begin
            res_err_d = 1'b0;
        end else if (wd_expire) begin
            res_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            res_err_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            res_err_q <= res_err_d;
        end
    end

    assign bus.res_err = res_err_q;
`else
    assign wd_expire   = 1'b0;
    assign bus.res_err = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            armed_q      <= 1'b0;
            ack_q        <= '0;
            grant_q      <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_class_q  <= '0;
            res_answer_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            armed_q      <= armed_d;
            ack_q        <= ack_d;
            grant_q      <= grant_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_class_q  <= res_class_d;
            res_answer_q <= res_answer_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (found) state_d = S_GRANT;
            S_GRANT: state_d = S_START;
            S_START: state_d = S_BUSY;
            S_BUSY:  if (done_qual || wd_expire) state_d = S_HOLD;
            S_HOLD:  if (handshake) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        ptr_d        = ptr_q;
        armed_d      = armed_q;
        ack_d        = ack;
        grant_d      = grant_q;
        res_valid_d  = res_valid_q;
        res_id_d     = res_id_q;
        res_class_d  = res_class_q;
        res_answer_d = res_answer_q;

        if (state_q == S_IDLE && found) begin
            grant_d  = NREQ'(1) << pick;
            res_id_d = pick;
        end

        if (state_q == S_START) begin
            armed_d = 1'b0;
        end else if (state_q == S_BUSY && !bus.mlp_done) begin
            armed_d = 1'b1;
        end

        if (done_qual) begin
            res_valid_d  = 1'b1;
            res_class_d  = encode_class(bus.mlp_maxi);
            res_answer_d = bus.mlp_answer;
        end else if (wd_expire) begin
            res_valid_d  = 1'b1;
            res_class_d  = 4'hF;
            res_answer_d = '0;
        end

        if (handshake) begin
            res_valid_d = 1'b0;
            grant_d     = '0;
            ptr_d       = (res_id_q == IDW'(NREQ - 1)) ? '0 : res_id_q + 1'b1;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        ack       = NREQ'(handshake) << res_id_q;
        mlp_start = (state_q == S_START);
    end

    assign bus.ack        = ack;
    assign bus.mlp_start  = mlp_start;
    assign bus.grant      = grant_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_class  = res_class_q;
    assign bus.res_answer = res_answer_q;

endmodule

// File: tb/tb_mlp_share_arbiter.sv
module tb_mlp_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 3;
    localparam int TMO  = 64;

    logic clk;
    logic rst;

    mlp_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    mlp_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: round-robin pointer and the one-cycle post-ack mask
    int              m_ptr  = 0;
    logic [NREQ-1:0] m_mask = '0;

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] exp_class(input logic [9:0] v);
        if ($countones(v) == 1) return 4'($clog2(v));
        return 4'hF;
    endfunction

    function automatic int rr_expect(input logic [NREQ-1:0] elig, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (elig[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req = '0; bus.mlp_done = 1'b0; bus.res_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        m_ptr = 0; m_mask = '0;
    endtask

    // Entered on the cycle where res_valid must first be 1 (after #1).
    task automatic finish_job(input int owner, input logic [3:0] ecls, input logic [79:0] eans,
                              input logic eerr, input int rwait, input bit drop);
        #1;
        n_checks++;
        if ({bus.res_valid, bus.res_id, bus.res_class, bus.res_err} !== {1'b1, IDW'(owner), ecls, eerr})
            $display("FAIL result_fields: got valid=%b id=%0d class=%h err=%b, expected valid=1 id=%0d class=%h err=%b",
                     bus.res_valid, bus.res_id, bus.res_class, bus.res_err, owner, ecls, eerr);
        else n_pass++;
        n_checks++;
        if (bus.res_answer !== eans)
            $display("FAIL result_answer: got %h expected %h", bus.res_answer, eans);
        else n_pass++;
        for (int k = 0; k < rwait; k++) begin
            step(); #1;
            n_checks++;
            if ({bus.res_valid, bus.res_id, bus.res_class, bus.res_err, bus.res_answer, bus.grant, bus.ack, bus.mlp_start}
                !== {1'b1, IDW'(owner), ecls, eerr, eans, oh(owner), {NREQ{1'b0}}, 1'b0})
                $display("FAIL backpressure_stable: got valid=%b id=%0d class=%h grant=%b ack=%b start=%b",
                         bus.res_valid, bus.res_id, bus.res_class, bus.grant, bus.ack, bus.mlp_start);
            else n_pass++;
        end
        step();
        bus.res_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.ack !== oh(owner))
            $display("FAIL ack_pulse: got %b expected %b", bus.ack, oh(owner));
        else n_pass++;
        step();
        bus.res_ready = 1'b0;
        if (drop) bus.req[owner] = 1'b0;
        #1;
        n_checks++;
        if ({bus.res_valid, bus.grant, bus.ack} !== {1'b0, {NREQ{1'b0}}, {NREQ{1'b0}}})
            $display("FAIL release: got valid=%b grant=%b ack=%b expected all zero",
                     bus.res_valid, bus.grant, bus.ack);
        else n_pass++;
        m_ptr  = (owner + 1) % NREQ;
        m_mask = oh(owner);
    endtask

    // Entered on cycle 0: DUT idle, req applied. Done rises lat cycles after start.
    task automatic do_job(input int owner, input int lat, input logic [9:0] maxi, input logic [79:0] ans,
                          input logic [3:0] ecls, input int rwait, input bit drop);
        step(); #1;
        n_checks++;
        if ({bus.grant, bus.mlp_start} !== {oh(owner), 1'b0})
            $display("FAIL grant_cycle1: got grant=%b start=%b expected grant=%b start=0",
                     bus.grant, bus.mlp_start, oh(owner));
        else n_pass++;
        step(); #1;
        n_checks++;
        if ({bus.grant, bus.mlp_start} !== {oh(owner), 1'b1})
            $display("FAIL start_cycle2: got grant=%b start=%b expected grant=%b start=1",
                     bus.grant, bus.mlp_start, oh(owner));
        else n_pass++;
        for (int c = 3; c < 2 + lat; c++) begin
            step(); #1;
            n_checks++;
            if ({bus.res_valid, bus.mlp_start, bus.grant} !== {1'b0, 1'b0, oh(owner)})
                $display("FAIL busy_wait: cycle %0d got valid=%b start=%b grant=%b",
                         c, bus.res_valid, bus.mlp_start, bus.grant);
            else n_pass++;
        end
        step();
        bus.mlp_done = 1'b1; bus.mlp_maxi = maxi; bus.mlp_answer = ans;
        #1;
        n_checks++;
        if (bus.res_valid !== 1'b0)
            $display("FAIL valid_early: got %b expected 0", bus.res_valid);
        else n_pass++;
        step();
        bus.mlp_done = 1'b0; bus.mlp_maxi = 10'($urandom); bus.mlp_answer = {$urandom, $urandom, 16'($urandom)};
        finish_job(owner, ecls, ans, 1'b0, rwait, drop);
    endtask

    task automatic run_job(input int lat, input logic [9:0] maxi, input logic [79:0] ans,
                           input int rwait, input bit drop);
        logic [NREQ-1:0] elig;
        int owner;
        elig = bus.req & ~m_mask;
        if (elig == '0) begin
            step(); #1;
            n_checks++;
            if (bus.grant !== '0)
                $display("FAIL ack_mask: got grant=%b expected 0000", bus.grant);
            else n_pass++;
            m_mask = '0;
            elig   = bus.req;
        end
        owner = rr_expect(elig, m_ptr);
        do_job(owner, lat, maxi, ans, exp_class(maxi), rwait, drop);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = '1; bus.mlp_done = 1'b1; bus.res_ready = 1'b1;
        bus.mlp_maxi = 10'h3FF; bus.mlp_answer = '1;
        step(); step(); #1;
        n_checks++;
        if ({bus.grant, bus.ack, bus.mlp_start, bus.res_valid} !== '0)
            $display("FAIL reset_ctrl: got grant=%b ack=%b start=%b valid=%b",
                     bus.grant, bus.ack, bus.mlp_start, bus.res_valid);
        else n_pass++;
        n_checks++;
        if ({bus.res_id, bus.res_class, bus.res_answer, bus.res_err} !== '0)
            $display("FAIL reset_result: got id=%0d class=%h answer=%h err=%b",
                     bus.res_id, bus.res_class, bus.res_answer, bus.res_err);
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_single_job();
        bus.req = 4'b0010;
        do_job(1, 20, 10'b0000100000, 80'h0102030405060708090A, 4'd5, 0, 1);
    endtask

    task automatic test_round_robin();
        apply_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            do_job(i, $urandom_range(2, 6), 10'b1 << i, {$urandom, $urandom, 16'($urandom)}, 4'(i), 0, 1);
        end
    endtask

    task automatic test_back_to_back();
        bus.req = 4'b0001;
        run_job(3, 10'b0000000100, 80'hAA, 0, 0);
        run_job(2, 10'b1000000000, 80'h55, 0, 1);
    endtask

    task automatic test_stale_done();
        int owner;
        bus.req = 4'b0100;
        owner = rr_expect(bus.req & ~m_mask, m_ptr);
        bus.mlp_done = 1'b1; bus.mlp_maxi = 10'b1000000000; bus.mlp_answer = 80'hDEAD;
        step(); #1;
        n_checks++;
        if (bus.grant !== oh(owner)) $display("FAIL stale_grant: got %b expected %b", bus.grant, oh(owner));
        else n_pass++;
        step(); #1;
        n_checks++;
        if (bus.mlp_start !== 1'b1) $display("FAIL stale_start: got %b expected 1", bus.mlp_start);
        else n_pass++;
        for (int c = 3; c <= 8; c++) begin
            step();
            if (c == 7) bus.mlp_done = 1'b0;
            if (c == 8) begin
                bus.mlp_done = 1'b1; bus.mlp_maxi = 10'b0000000001; bus.mlp_answer = 80'hBEEF;
            end
            #1;
            n_checks++;
            if (bus.res_valid !== 1'b0) $display("FAIL stale_capture: cycle %0d got valid=%b expected 0", c, bus.res_valid);
            else n_pass++;
        end
        step();
        bus.mlp_done = 1'b0;
        finish_job(owner, 4'd0, 80'hBEEF, 1'b0, 0, 1);
    endtask

    task automatic test_backpressure();
        bus.req = 4'b0100;
        run_job(5, 10'b0000001000, 80'h1234_5678_9ABC_DEF0_1122, 10, 1);
    endtask

    task automatic test_invalid_vector();
        bus.req = 4'b0010;
        run_job(4, 10'b0000000000, 80'h77, 0, 1);
        bus.req = 4'b0001;
        run_job(4, 10'b0000000011, 80'h88, 1, 1);
    endtask

    task automatic test_reset_mid_job();
        bus.req = 4'b1000;
        for (int c = 1; c <= 4; c++) step();
        rst = 1'b1;
        step(); #1;
        n_checks++;
        if ({bus.grant, bus.ack, bus.mlp_start, bus.res_valid, bus.res_id, bus.res_class, bus.res_answer, bus.res_err} !== '0)
            $display("FAIL reset_mid_job: got grant=%b ack=%b start=%b valid=%b id=%0d class=%h err=%b",
                     bus.grant, bus.ack, bus.mlp_start, bus.res_valid, bus.res_id, bus.res_class, bus.res_err);
        else n_pass++;
        rst = 1'b0;
        m_ptr = 0; m_mask = '0;
        run_job(3, 10'b0001000000, 80'h99, 0, 1);
    endtask

    task automatic test_random();
        logic [9:0] maxi;
        for (int n = 0; n < 12; n++) begin
            bus.req = bus.req | NREQ'($urandom);
            if (bus.req == '0) bus.req = oh($urandom_range(0, NREQ - 1));
            maxi = ($urandom_range(0, 1) == 1) ? (10'b1 << $urandom_range(0, 9)) : 10'($urandom);
            run_job($urandom_range(2, 12), maxi, {$urandom, $urandom, 16'($urandom)}, $urandom_range(0, 3), 1);
        end
        while (bus.req != '0) begin
            run_job(2, 10'b0000010000, 80'h1, 0, 1);
        end
    endtask

`ifdef MLP_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int owner;
        int seen;
        bus.req = 4'b0010;
        bus.mlp_done = 1'b0;
        owner = rr_expect(bus.req & ~m_mask, m_ptr);
        step(); step(); #1;
        n_checks++;
        if (bus.mlp_start !== 1'b1) $display("FAIL wd_start: got %b expected 1", bus.mlp_start);
        else n_pass++;
        seen = -1;
        for (int c = 3; c <= 3 + TMO + 8; c++) begin
            step(); #1;
            if (bus.res_valid === 1'b1) begin
                seen = c;
                break;
            end
        end
        n_checks++;
        if (seen != 3 + TMO) $display("FAIL wd_timeout_cycle: got %0d expected %0d", seen, 3 + TMO);
        else n_pass++;
        if (seen >= 0) finish_job(owner, 4'hF, 80'h0, 1'b1, 0, 1);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.req = '0; bus.mlp_done = 1'b0; bus.res_ready = 1'b0;
        bus.mlp_maxi = '0; bus.mlp_answer = '0;
        test_reset();
        test_single_job();
        test_round_robin();
        test_back_to_back();
        test_stale_done();
        test_backpressure();
        test_invalid_vector();
        test_reset_mid_job();
        test_random();
`ifdef MLP_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
